// File: rtl/ball_engine.sv
// Fixed-point pong ball: serve delay, wall bounce, latched paddle hits and goal pulses.
// Define BALL_ENGINE_SPEEDUP_EN to add a saturating |vx| boost on every single-sided paddle hit.
module ball_engine #(
  parameter int X_POS_W      = 10,
  parameter int Y_POS_W      = 10,
  parameter int FRAC_W       = 4,
  parameter int SPEED_W      = 8,
  parameter int SCREEN_H_RES = 640,
  parameter int SCREEN_V_RES = 480,
  parameter int BORDER       = 5,
  parameter int BALL_SIDE    = 8,
  parameter int SERVE_FRAMES = 60,
  parameter int MAX_SPEED    = 96
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      new_frame_i,
  input  logic                      game_en_i,
  input  logic                      hit_left_i,
  input  logic                      hit_right_i,
  input  logic signed [SPEED_W-1:0] deflect_vy_i,
  input  logic signed [SPEED_W-1:0] serve_vx_i,
  input  logic signed [SPEED_W-1:0] serve_vy_i,
  output logic [X_POS_W-1:0]        ball_x_o,
  output logic [Y_POS_W-1:0]        ball_y_o,
  output logic                      goal_left_o,
  output logic                      goal_right_o,
  output logic                      moving_o
);

  localparam int XW    = X_POS_W + FRAC_W;
  localparam int YW    = Y_POS_W + FRAC_W;
  localparam int ONE   = 2 ** FRAC_W;
  localparam int X_MAX = SCREEN_H_RES - BORDER - BALL_SIDE;
  localparam int Y_MAX = SCREEN_V_RES - BORDER - BALL_SIDE;
  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [XW-1:0]        X_CTR    = XW'((SCREEN_H_RES - BALL_SIDE) / 2 * ONE);
  localparam logic [YW-1:0]        Y_CTR    = YW'((SCREEN_V_RES - BALL_SIDE) / 2 * ONE);
  localparam logic signed [XW:0]   X_LO     = (XW+1)'(BORDER * ONE);
  localparam logic signed [XW:0]   X_HI     = (XW+1)'((X_MAX + 1) * ONE);
  localparam logic signed [YW:0]   Y_LO     = (YW+1)'(BORDER * ONE);
  localparam logic signed [YW:0]   Y_HI     = (YW+1)'((Y_MAX + 1) * ONE);
  localparam logic [XW-1:0]        X_LO_POS = XW'(BORDER * ONE);
  localparam logic [XW-1:0]        X_HI_POS = XW'(X_MAX * ONE);
  localparam logic [YW-1:0]        Y_LO_POS = YW'(BORDER * ONE);
  localparam logic [YW-1:0]        Y_HI_POS = YW'(Y_MAX * ONE);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  if (MAX_SPEED >= 2 ** (SPEED_W - 1)) begin : g_bad_max_speed
    $error("MAX_SPEED must be below 2^(SPEED_W-1)");
  end

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_MOVE, S_SCORED} state_e;

  state_e                     state_q;
  logic [XW-1:0]              x_q, x_d;
  logic [YW-1:0]              y_q, y_d;
  logic signed [SPEED_W-1:0]  vx_q, vx_d, vy_q, vy_d;
  logic [CNT_W-1:0]           cnt_q;
  logic                       hit_l_q, hit_r_q;
  logic                       goal_l_q, goal_r_q, goal_l_d, goal_r_d;
  logic                       moving_q;

  logic                       hit_l, hit_r;
  logic signed [SPEED_W-1:0]  vx_abs, vx_mag, vy_h;
  logic signed [XW:0]         nx;
  logic signed [YW:0]         ny;

  function automatic logic signed [SPEED_W-1:0] abs_v(input logic signed [SPEED_W-1:0] v);
    return v[SPEED_W-1] ? -v : v;
  endfunction

`ifdef BALL_ENGINE_SPEEDUP_EN
  localparam logic signed [SPEED_W:0] SPD_STEP = (SPEED_W+1)'(ONE / 4);
  localparam logic signed [SPEED_W:0] SPD_MAX  = (SPEED_W+1)'(MAX_SPEED);

  function automatic logic signed [SPEED_W-1:0] speed_up(input logic signed [SPEED_W-1:0] mag);
    logic signed [SPEED_W:0] sum;
    sum = {mag[SPEED_W-1], mag} + SPD_STEP;
    if (sum > SPD_MAX) return SPD_MAX[SPEED_W-1:0];
    return sum[SPEED_W-1:0];
  endfunction
`endif

  // Frame update for MOVE: hits, then position, then walls, then goals
  always_comb begin
    hit_l  = hit_l_q | hit_left_i;
    hit_r  = hit_r_q | hit_right_i;
    vx_abs = abs_v(vx_q);
`ifdef BALL_ENGINE_SPEEDUP_EN
    vx_mag = speed_up(vx_abs);
`else
    vx_mag = vx_abs;
`endif
    vx_d = vx_q;
    vy_h = vy_q;
    if (hit_l && hit_r) begin
      vx_d = -vx_q;
    end else if (hit_l) begin
      vx_d = vx_mag;
      vy_h = deflect_vy_i;
    end else if (hit_r) begin
      vx_d = -vx_mag;
      vy_h = deflect_vy_i;
    end

    // One spare bit so a step past zero reads as negative instead of wrapping
    nx = $signed({1'b0, x_q}) + {{(XW+1-SPEED_W){vx_d[SPEED_W-1]}}, vx_d};
    ny = $signed({1'b0, y_q}) + {{(YW+1-SPEED_W){vy_h[SPEED_W-1]}}, vy_h};

    y_d  = ny[YW-1:0];
    vy_d = vy_h;
    if (ny < Y_LO) begin
      y_d  = Y_LO_POS;
      vy_d = abs_v(vy_h);
    end else if (ny >= Y_HI) begin
      y_d  = Y_HI_POS;
      vy_d = -abs_v(vy_h);
    end

    x_d      = nx[XW-1:0];
    goal_l_d = 1'b0;
    goal_r_d = 1'b0;
    if (nx < X_LO) begin
      x_d      = X_LO_POS;
      goal_l_d = 1'b1;
    end else if (nx >= X_HI) begin
      x_d      = X_HI_POS;
      goal_r_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      x_q      <= X_CTR;
      y_q      <= Y_CTR;
      vx_q     <= '0;
      vy_q     <= '0;
      cnt_q    <= '0;
      hit_l_q  <= 1'b0;
      hit_r_q  <= 1'b0;
      goal_l_q <= 1'b0;
      goal_r_q <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      goal_l_q <= 1'b0;
      goal_r_q <= 1'b0;
      if (!game_en_i) begin
        state_q  <= S_IDLE;
        x_q      <= X_CTR;
        y_q      <= Y_CTR;
        vx_q     <= '0;
        vy_q     <= '0;
        cnt_q    <= '0;
        hit_l_q  <= 1'b0;
        hit_r_q  <= 1'b0;
        moving_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_SERVE;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            vx_q    <= serve_vx_i;
            vy_q    <= serve_vy_i;
            cnt_q   <= '0;
            hit_l_q <= 1'b0;
            hit_r_q <= 1'b0;
          end
          S_SERVE: begin
            hit_l_q <= 1'b0;
            hit_r_q <= 1'b0;
            if (new_frame_i) begin
              if (cnt_q == CNT_LAST) begin
                state_q  <= S_MOVE;
                moving_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          S_MOVE: begin
            if (new_frame_i) begin
              x_q      <= x_d;
              y_q      <= y_d;
              vx_q     <= vx_d;
              vy_q     <= vy_d;
              hit_l_q  <= 1'b0;
              hit_r_q  <= 1'b0;
              goal_l_q <= goal_l_d;
              goal_r_q <= goal_r_d;
              if (goal_l_d || goal_r_d) begin
                state_q  <= S_SCORED;
                moving_q <= 1'b0;
              end
            end else begin
              hit_l_q <= hit_l;
              hit_r_q <= hit_r;
            end
          end
          default: begin
            state_q <= S_SERVE;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            vx_q    <= serve_vx_i;
            vy_q    <= serve_vy_i;
            cnt_q   <= '0;
            hit_l_q <= 1'b0;
            hit_r_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ball_x_o     = x_q[XW-1:FRAC_W];
  assign ball_y_o     = y_q[YW-1:FRAC_W];
  assign goal_left_o  = goal_l_q;
  assign goal_right_o = goal_r_q;
  assign moving_o     = moving_q;

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: cycle-level integer model feeding a scoreboard, plus directed spot checks.
`timescale 1ns/1ps
module tb_ball_engine;
  localparam int SF    = 60;
  localparam int MAXS  = 24;
  localparam int XC    = 316 * 16;
  localparam int YC    = 236 * 16;
  localparam int XMAXP = 640 - 5 - 8;
  localparam int YMAXP = 480 - 5 - 8;
  localparam int M_IDLE = 0, M_SERVE = 1, M_MOVE = 2, M_SCORED = 3;

  logic              clk = 1'b0;
  logic              rst, new_frame, game_en, hit_left, hit_right;
  logic signed [7:0] dvy, svx, svy;
  logic [9:0]        ball_x, ball_y;
  logic              goal_l, goal_r, moving;

  ball_engine #(.SERVE_FRAMES(SF), .MAX_SPEED(MAXS)) dut (
    .clk_i(clk), .rst_i(rst), .new_frame_i(new_frame), .game_en_i(game_en),
    .hit_left_i(hit_left), .hit_right_i(hit_right), .deflect_vy_i(dvy),
    .serve_vx_i(svx), .serve_vy_i(svy), .ball_x_o(ball_x), .ball_y_o(ball_y),
    .goal_left_o(goal_l), .goal_right_o(goal_r), .moving_o(moving)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [22:0] sb[$];

  int ms, mx, my, mvx, mvy, mcnt;
  bit mhl, mhr, mgl, mgr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_cycle();
    int nx, ny, mag;
    bit hl, hr;
    mgl = 1'b0;
    mgr = 1'b0;
    if (rst || !game_en) begin
      ms = M_IDLE; mx = XC; my = YC; mvx = 0; mvy = 0; mcnt = 0; mhl = 0; mhr = 0;
    end else if (ms == M_IDLE) begin
      ms = M_SERVE; mcnt = 0; mvx = svx; mvy = svy;
    end else if (ms == M_SERVE) begin
      if (new_frame) begin
        if (mcnt == SF - 1) ms = M_MOVE;
        else mcnt++;
      end
    end else if (ms == M_SCORED) begin
      ms = M_SERVE; mx = XC; my = YC; mvx = svx; mvy = svy; mcnt = 0;
    end else begin
      hl = mhl | hit_left;
      hr = mhr | hit_right;
      mhl = hl;
      mhr = hr;
      if (new_frame) begin
        mhl = 0;
        mhr = 0;
        mag = (mvx < 0) ? -mvx : mvx;
`ifdef BALL_ENGINE_SPEEDUP_EN
        mag = (mag + 4 > MAXS) ? MAXS : mag + 4;
`endif
        if (hl && hr) mvx = -mvx;
        else if (hl) begin mvx = mag;  mvy = dvy; end
        else if (hr) begin mvx = -mag; mvy = dvy; end
        nx = mx + mvx;
        ny = my + mvy;
        if ((ny >>> 4) < 5) begin
          ny = 5 * 16;
          if (mvy < 0) mvy = -mvy;
        end else if ((ny >>> 4) > YMAXP) begin
          ny = YMAXP * 16;
          if (mvy > 0) mvy = -mvy;
        end
        my = ny;
        if ((nx >>> 4) < 5) begin
          mgl = 1'b1; mx = 5 * 16; ms = M_SCORED;
        end else if ((nx >>> 4) > XMAXP) begin
          mgr = 1'b1; mx = XMAXP * 16; ms = M_SCORED;
        end else begin
          mx = nx;
        end
      end
    end
  endtask

  // One clock: model predicts the post-edge outputs, scoreboard compares them after the edge
  task automatic cyc(input bit strobe);
    logic [9:0]  ex, ey;
    logic [22:0] got, exp;
    new_frame = strobe;
    model_cycle();
    ex = 10'(mx >>> 4);
    ey = 10'(my >>> 4);
    sb.push_back({ex, ey, mgl, mgr, (ms == M_MOVE)});
    @(posedge clk);
    #1;
    got = {ball_x, ball_y, goal_l, goal_r, moving};
    exp = sb.pop_front();
    check("model", 32'(got), 32'(exp));
    new_frame = 1'b0;
    hit_left  = 1'b0;
    hit_right = 1'b0;
  endtask

  task automatic frame();
    repeat (3) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic serve(input logic signed [7:0] vx, input logic signed [7:0] vy);
    game_en = 1'b0;
    cyc(1'b0);
    svx = vx;
    svy = vy;
    game_en = 1'b1;
    cyc(1'b0);
    repeat (SF) frame();
  endtask

  initial begin
    rst = 1'b1; game_en = 1'b0; new_frame = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
    dvy = '0; svx = '0; svy = '0;
    cyc(1'b0);
    cyc(1'b0);
    check("rst_x", 32'(ball_x), 316);
    check("rst_y", 32'(ball_y), 236);
    check("rst_goals", 32'({goal_l, goal_r}), 0);
    check("rst_moving", 32'(moving), 0);

    // Serve delay then first step at 1 px/frame
    rst = 1'b0; svx = 16; svy = 0; game_en = 1'b1;
    cyc(1'b0);
    for (int i = 1; i <= SF; i++) begin
      frame();
      if (i == SF - 1) check("serve_not_moving", 32'(moving), 0);
    end
    check("serve_moving", 32'(moving), 1);
    check("serve_x", 32'(ball_x), 316);
    frame();
    check("first_step_x", 32'(ball_x), 317);

    // Half-pixel speed
    serve(8, 0);
    frame();
    check("half_x1", 32'(ball_x), 316);
    repeat (3) frame();
    check("half_x4", 32'(ball_x), 318);

    // Top and bottom walls
    serve(0, -32);
    repeat (115) frame();
    check("top_pre", 32'(ball_y), 6);
    frame();
    check("top_clamp", 32'(ball_y), 5);
    frame();
    check("top_bounce", 32'(ball_y), 7);
    repeat (230) frame();
    check("bot_pre", 32'(ball_y), 467);
    frame();
    check("bot_clamp", 32'(ball_y), 467);
    frame();
    check("bot_bounce", 32'(ball_y), 465);

    // Paddle hits: right only, then both together
    serve(16, 0);
    dvy = -8;
    hit_right = 1'b1;
    cyc(1'b0);
    frame();
`ifdef BALL_ENGINE_SPEEDUP_EN
    check("hit_r_x", 32'(ball_x), 314);
`else
    check("hit_r_x", 32'(ball_x), 315);
`endif
    check("hit_r_y", 32'(ball_y), 235);
    hit_left = 1'b1;
    hit_right = 1'b1;
    cyc(1'b0);
    frame();
    check("hit_both_x", 32'(ball_x), 316);
    check("hit_both_y", 32'(ball_y), 235);

    // Repeated left hits: speed-up saturation when enabled
    serve(16, 0);
    dvy = 0;
    for (int i = 0; i < 3; i++) begin
      hit_left = 1'b1;
      cyc(1'b0);
      frame();
    end
`ifdef BALL_ENGINE_SPEEDUP_EN
    check("speed_x", 32'(ball_x), 320);
`else
    check("speed_x", 32'(ball_x), 319);
`endif

    // Left goal, SCORED, back to serve
    serve(-64, 0);
    repeat (77) frame();
    check("gl_pre_x", 32'(ball_x), 8);
    frame();
    check("gl_pulse", 32'({goal_l, goal_r}), 32'b10);
    cyc(1'b0);
    check("gl_end", 32'({goal_l, goal_r}), 0);
    check("gl_recentre", 32'(ball_x), 316);
    check("gl_not_moving", 32'(moving), 0);

    // Right goal
    serve(64, 0);
    repeat (77) frame();
    check("gr_pre_x", 32'(ball_x), 624);
    frame();
    check("gr_pulse", 32'({goal_l, goal_r}), 32'b01);
    cyc(1'b0);
    check("gr_end", 32'({goal_l, goal_r}), 0);

    // Game disabled mid-move
    serve(16, 0);
    repeat (3) frame();
    game_en = 1'b0;
    cyc(1'b0);
    check("dis_x", 32'(ball_x), 316);
    check("dis_moving", 32'(moving), 0);
    check("dis_goals", 32'({goal_l, goal_r}), 0);

    // Reset mid-move
    serve(16, 0);
    repeat (2) frame();
    hit_left = 1'b1;
    cyc(1'b0);
    rst = 1'b1;
    cyc(1'b0);
    check("mid_rst_x", 32'(ball_x), 316);
    check("mid_rst_moving", 32'(moving), 0);
    rst = 1'b0;
    cyc(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
